// File: rtl/deserialize.sv
// deserialize: serial-to-parallel stage with ready/valid on both sides.
// Accepts one bit per input handshake and assembles width_p-bit words. Each
// completed word is presented on a registered parallel output. One assembly
// word and one output word are held, so a continuous stream runs with no
// bubbles.
//
// Optional build macro: DESERIALIZE_LSB_FIRST_EN
//   undefined : MSB-first, so the first accepted bit lands in data_o[width_p-1]
//   defined   : LSB-first, so the first accepted bit lands in data_o[0]
//
// Ports:
//   clk_i    in   rising-edge clock
//   reset_i  in   synchronous active-high reset
//   valid_i  in   serial bit valid
//   data_i   in   serial bit
//   ready_o  out  stage can accept a serial bit this cycle (registered state only)
//   valid_o  out  data_o holds a completed word
//   data_o   out  assembled word (width_p bits)
//   ready_i  in   downstream accepts data_o this cycle
module deserialize #(
   parameter int width_p = 5
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               valid_i,
   input  logic               data_i,
   output logic               ready_o,
   output logic               valid_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i
);

   localparam int cnt_w = (width_p > 1) ? $clog2(width_p) : 1;
   localparam logic [cnt_w-1:0] last_c = cnt_w'(width_p - 1);

   logic [cnt_w-1:0]   count_r;
   logic               full_r;
   logic [width_p-1:0] asm_r;
   logic [width_p-1:0] data_r;
   logic               valid_r;

   logic               accept;
   logic               last_bit;
   logic               complete;
   logic               out_can_load;
   logic               load_held;
   logic               load_new;
   logic [width_p-1:0] shifted;

   assign ready_o      = ~full_r;
   assign valid_o      = valid_r;
   assign data_o       = data_r;

   assign accept       = valid_i & ready_o;
   assign last_bit     = (count_r == last_c);
   assign complete     = accept & last_bit;
   assign out_can_load = ~valid_r | ready_i;
   // A held word always wins. While full, ready_o is low, so no bit can
   // complete in the same cycle.
   assign load_held    = full_r & out_can_load;
   assign load_new     = complete & out_can_load;

`ifdef DESERIALIZE_LSB_FIRST_EN
   assign shifted = {data_i, asm_r[width_p-1:1]};
`else
   assign shifted = {asm_r[width_p-2:0], data_i};
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_r <= '0;
         full_r  <= 1'b0;
         asm_r   <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
      end else begin
         if (accept) begin
            asm_r   <= shifted;
            count_r <= last_bit ? '0 : count_r + 1'b1;
         end

         // The completed word stays parked in asm_r until the output frees up.
         if (complete & ~out_can_load) begin
            full_r <= 1'b1;
         end else if (load_held) begin
            full_r <= 1'b0;
         end

         if (load_held) begin
            data_r  <= asm_r;
            valid_r <= 1'b1;
         end else if (load_new) begin
            data_r  <= shifted;
            valid_r <= 1'b1;
         end else if (ready_i) begin
            valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_deserialize.sv
// Directed bench for deserialize (width_p = 5). Inputs are applied 1 time
// unit after a rising edge, and outputs are checked at that same point, so
// they reflect the edge that just occurred.
module tb_deserialize;

   localparam int W = 5;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         valid_i;
   logic         data_i;
   logic         ready_o;
   logic         valid_o;
   logic [W-1:0] data_o;
   logic         ready_i;

   int n_cmp = 0;
   int n_err = 0;

   deserialize #(.width_p(W)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .ready_i (ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Returns the i-th serial bit to send so that the assembled word equals w
   // in the current build order.
   function automatic logic bit_of(input logic [W-1:0] w, input int i);
`ifdef DESERIALIZE_LSB_FIRST_EN
      return w[i];
`else
      return w[W-1-i];
`endif
   endfunction

   logic [W-1:0] t1_bits;
   logic [W-1:0] t1_exp;
   logic [W-1:0] t5_exp;
   logic [W-1:0] word_a;
   logic [W-1:0] word_b;
   logic [W-1:0] t4_words [4];
   logic [W-1:0] t6_word;

   initial begin
      reset_i = 1'b1;
      valid_i = 1'b0;
      data_i  = 1'b0;
      ready_i = 1'b0;
      // Serial order, first bit sent = t1_bits[4].
      t1_bits = 5'b10110;
`ifdef DESERIALIZE_LSB_FIRST_EN
      t1_exp  = 5'b01101;
      t5_exp  = 5'b10000;
`else
      t1_exp  = 5'b10110;
      t5_exp  = 5'b00001;
`endif
      word_a = 5'b11001;
      word_b = 5'b00111;
      t4_words[0] = 5'b10101;
      t4_words[1] = 5'b01110;
      t4_words[2] = 5'b11111;
      t4_words[3] = 5'b00010;
      t6_word = 5'b01011;

      #1;
      step();
      step();
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_data_o",  32'(data_o),  32'd0);
      chk("rst_ready_o", 32'(ready_o), 32'd1);
      reset_i = 1'b0;

      // Test 1: basic word, ready_i high.
      ready_i = 1'b1;
      for (int i = 0; i < W; i++) begin
         valid_i = 1'b1;
         data_i  = t1_bits[W-1-i];
         chk("t1_ready_o", 32'(ready_o), 32'd1);
         step();
         if (i < W - 1) chk("t1_valid_early", 32'(valid_o), 32'd0);
      end
      valid_i = 1'b0;
      chk("t1_valid_o", 32'(valid_o), 32'd1);
      chk("t1_data_o",  32'(data_o),  32'(t1_exp));
      chk("t1_ready_end", 32'(ready_o), 32'd1);
      step();
      chk("t1_valid_drop", 32'(valid_o), 32'd0);

      // Test 3: stalled output, A then B back to back.
      ready_i = 1'b0;
      for (int i = 0; i < 2 * W; i++) begin
         valid_i = 1'b1;
         data_i  = (i < W) ? bit_of(word_a, i) : bit_of(word_b, i - W);
         chk("t3_ready_stream", 32'(ready_o), 32'd1);
         step();
         if (i == W - 1) begin
            chk("t3_a_valid", 32'(valid_o), 32'd1);
            chk("t3_a_data",  32'(data_o),  32'(word_a));
         end
      end
      valid_i = 1'b0;
      chk("t3_full_ready", 32'(ready_o), 32'd0);
      chk("t3_hold_valid", 32'(valid_o), 32'd1);
      chk("t3_hold_data",  32'(data_o),  32'(word_a));
      step();
      step();
      chk("t3_hold_data2", 32'(data_o),  32'(word_a));
      chk("t3_full_ready2", 32'(ready_o), 32'd0);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      chk("t3_b_valid", 32'(valid_o), 32'd1);
      chk("t3_b_data",  32'(data_o),  32'(word_b));
      chk("t3_b_ready", 32'(ready_o), 32'd1);
      ready_i = 1'b1;
      step();
      chk("t3_drain", 32'(valid_o), 32'd0);

      // Test 4: continuous stream of 4 words.
      ready_i = 1'b1;
      for (int k = 0; k < 4 * W; k++) begin
         valid_i = 1'b1;
         data_i  = bit_of(t4_words[k / W], k % W);
         step();
         chk("t4_ready_o", 32'(ready_o), 32'd1);
         chk("t4_valid_o", 32'(valid_o), ((k % W) == W - 1) ? 32'd1 : 32'd0);
         if ((k % W) == W - 1) chk("t4_data_o", 32'(data_o), 32'(t4_words[k / W]));
      end
      valid_i = 1'b0;
      step();
      chk("t4_valid_end", 32'(valid_o), 32'd0);

      // Test 5: reset mid-word discards the partial bits.
      for (int i = 0; i < 3; i++) begin
         valid_i = 1'b1;
         data_i  = 1'b1;
         step();
      end
      valid_i = 1'b0;
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      chk("t5_rst_valid", 32'(valid_o), 32'd0);
      chk("t5_rst_ready", 32'(ready_o), 32'd1);
      for (int i = 0; i < W; i++) begin
         valid_i = 1'b1;
         data_i  = (i == W - 1) ? 1'b1 : 1'b0;
         step();
         if (i < W - 1) chk("t5_no_word", 32'(valid_o), 32'd0);
      end
      valid_i = 1'b0;
      chk("t5_valid_o", 32'(valid_o), 32'd1);
      chk("t5_data_o",  32'(data_o),  32'(t5_exp));
      step();

      // Test 6: valid_i toggling, gaps between bits.
      for (int i = 0; i < W; i++) begin
         valid_i = 1'b1;
         data_i  = bit_of(t6_word, i);
         step();
         chk("t6_valid_acc", 32'(valid_o), (i == W - 1) ? 32'd1 : 32'd0);
         if (i == W - 1) chk("t6_data_o", 32'(data_o), 32'(t6_word));
         valid_i = 1'b0;
         data_i  = ~data_i;
         step();
         chk("t6_valid_gap", 32'(valid_o), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
